// File: rtl/ex_operand_stage.sv
// Purpose  : ID/EX pipeline register with EX-stage operand forwarding (MEM > WB > held register file).
// Latency  : 1 cycle from ID capture to EX outputs; forwarding is combinational on held fields + mem/wb.
// Backpres.: stall holds the slot (refreshing held operands from WB); flush loads a bubble; reset > flush > stall.
//
// Ports:
//   clk, reset                       clock and synchronous active-high reset
//   stall, flush                     hazard-unit controls
//   id_valid, id_rs, id_rt, id_rd    decoded instruction identity and register numbers
//   id_rdata1, id_rdata2, id_imm     register-file read data and extended immediate
//   id_regdst, id_alusrc, id_regwrite  destination select, ALU-B select, register write enable
//   mem_regwrite, mem_wreg, mem_fwd_data   MEM-stage result for forwarding
//   wb_regwrite, wb_wreg, wb_data          WB-stage result for forwarding and stall refresh
//   ex_valid, ex_alu_a, ex_alu_b, ex_store_data, ex_wreg, ex_regwrite   EX-stage outputs
module ex_operand_stage #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int LINK_REG = 31,
  parameter int FWD_EN   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [1:0]        id_regdst,
  input  logic              id_alusrc,
  input  logic              id_regwrite,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_wreg,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_wreg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_alu_a,
  output logic [DATA_W-1:0] ex_alu_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_wreg,
  output logic              ex_regwrite
);

  localparam logic [REG_AW-1:0] LINK = REG_AW'(LINK_REG);

  // Held ID/EX fields
  logic              h_valid;
  logic [REG_AW-1:0] h_rs;
  logic [REG_AW-1:0] h_rt;
  logic [REG_AW-1:0] h_rd;
  logic [DATA_W-1:0] h_rdata1;
  logic [DATA_W-1:0] h_rdata2;
  logic [DATA_W-1:0] h_imm;
  logic [1:0]        h_regdst;
  logic              h_alusrc;
  logic              h_regwrite;

  // WB hits on held source registers, used for the stall refresh.
  logic wb_hit_rs;
  logic wb_hit_rt;

  assign wb_hit_rs = wb_regwrite && (wb_wreg != '0) && (wb_wreg == h_rs);
  assign wb_hit_rt = wb_regwrite && (wb_wreg != '0) && (wb_wreg == h_rt);

  always_ff @(posedge clk) begin
    if (reset) begin
      h_valid    <= 1'b0;
      h_rs       <= '0;
      h_rt       <= '0;
      h_rd       <= '0;
      h_rdata1   <= '0;
      h_rdata2   <= '0;
      h_imm      <= '0;
      h_regdst   <= '0;
      h_alusrc   <= 1'b0;
      h_regwrite <= 1'b0;
    end else if (flush) begin
      // Bubble: clearing rs/rt keeps the empty slot from matching any forward.
      h_valid    <= 1'b0;
      h_regwrite <= 1'b0;
      h_rs       <= '0;
      h_rt       <= '0;
    end else if (stall) begin
      // A producer may retire from WB while we sit here; capture its value
      // now, or the held operand would go stale once WB moves on.
      if (FWD_EN != 0) begin
        if (wb_hit_rs) h_rdata1 <= wb_data;
        if (wb_hit_rt) h_rdata2 <= wb_data;
      end
    end else begin
      h_valid    <= id_valid;
      h_rs       <= id_rs;
      h_rt       <= id_rt;
      h_rd       <= id_rd;
      h_rdata1   <= id_rdata1;
      h_rdata2   <= id_rdata2;
      h_imm      <= id_imm;
      h_regdst   <= id_regdst;
      h_alusrc   <= id_alusrc;
      h_regwrite <= id_regwrite & id_valid;
    end
  end

  // Forwarding muxes. Register 0 is hardwired and never forwarded; MEM is the
  // younger producer so it wins over WB.
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  always_comb begin
    fwd_rs = h_rdata1;
    if ((FWD_EN != 0) && (h_rs != '0)) begin
      if (mem_regwrite && (mem_wreg == h_rs))
        fwd_rs = mem_fwd_data;
      else if (wb_regwrite && (wb_wreg == h_rs))
        fwd_rs = wb_data;
    end
  end

  always_comb begin
    fwd_rt = h_rdata2;
    if ((FWD_EN != 0) && (h_rt != '0)) begin
      if (mem_regwrite && (mem_wreg == h_rt))
        fwd_rt = mem_fwd_data;
      else if (wb_regwrite && (wb_wreg == h_rt))
        fwd_rt = wb_data;
    end
  end

  // Destination decode; a non-writing instruction reports register 0.
  logic [REG_AW-1:0] dest;

  always_comb begin
    case (h_regdst)
      2'd1:    dest = h_rd;
      2'd2:    dest = LINK;
      default: dest = h_rt;
    endcase
  end

  assign ex_valid      = h_valid;
  assign ex_regwrite   = h_valid & h_regwrite;
  assign ex_alu_a      = fwd_rs;
  assign ex_store_data = fwd_rt;
  assign ex_alu_b      = h_alusrc ? h_imm : fwd_rt;
  assign ex_wreg       = h_regwrite ? dest : '0;

endmodule
